lz_match_finder: RTL and testbench

LZ_MATCH_FINDER -- requirements
Module: lz_match_finder

---
 rtl/lz_match_finder.sv | 175 +++++++++++++++++
 tb/tb_lz_match_finder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/lz_match_finder.sv
// LZ77 match finder: serially compares the look-ahead against a WINDOW-byte history and
// emits one literal or (offset,length) token per search. Define LZ_MATCH_STATS_EN for token counters.

module lz_match_lane #(
    parameter int WINDOW = 16,
    parameter int W_BITS = 4,
    parameter int DIST   = 1
) (
    input  logic [WINDOW-1:0][7:0] hist,
    input  logic [3:0]             len,
    input  logic [7:0]             byte_n,
    input  logic                   alive,
    output logic                   hit
);
    logic [W_BITS-1:0] idx;

    // Candidate at distance DIST stays alive only while the match would not overlap the look-ahead.
    assign idx = W_BITS'(DIST - 1 - int'(len));
    assign hit = alive && (int'(len) < DIST) && (hist[idx] == byte_n);
endmodule

module lz_match_finder #(
    parameter int WINDOW  = 16,
    parameter int W_BITS  = 4,
    parameter int MAX_LEN = 15,
    parameter int N_BITS  = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_BITS:0]   size,
    input  logic [7:0]        byte_n,
    input  logic              flush,
    output logic [N_BITS-1:0] get_byte_n,
    output logic [N_BITS-1:0] remove_n_bytes,
    output logic              token_valid,
    input  logic              token_ready,
    output logic              token_is_match,
    output logic [7:0]        token_literal,
    output logic [W_BITS-1:0] token_offset,
    output logic [3:0]        token_length
`ifdef LZ_MATCH_STATS_EN
    ,
    output logic [15:0]       literal_count,
    output logic [15:0]       match_count
`endif
);
    localparam int CAP_IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_EMIT, S_CONSUME} state_t;

    state_t                    state, state_nxt;
    logic [WINDOW-1:0][7:0]    hist, hist_nxt;
    logic [MAX_LEN-1:0][7:0]   cap;
    logic [W_BITS:0]           hist_count, cnt_nxt;
    logic [W_BITS+1:0]         cnt_sum;
    logic [3:0]                len, fin_len;
    logic [4:0]                len_p1;
    logic [WINDOW-1:0]         alive, new_alive, alive_init;
    logic [W_BITS:0]           fin_dist;
    logic                      start, grow, any_new, fin_match;
    logic [7:0]                cap0;

    function automatic logic [W_BITS:0] lowest_dist(input logic [WINDOW-1:0] v);
        lowest_dist = '0;
        for (int i = WINDOW - 1; i >= 0; i--)
            if (v[i]) lowest_dist = (W_BITS+1)'(i + 1);
    endfunction

    for (genvar d = 1; d <= WINDOW; d++) begin : g_lane
        lz_match_lane #(.WINDOW(WINDOW), .W_BITS(W_BITS), .DIST(d)) u_lane (
            .hist   (hist),
            .len    (len),
            .byte_n (byte_n),
            .alive  (alive[d-1]),
            .hit    (new_alive[d-1])
        );
        assign alive_init[d-1] = (d <= int'(hist_count));
    end

    assign start     = (size >= (N_BITS+1)'(MAX_LEN)) || (flush && (size != '0));
    assign len_p1    = {1'b0, len} + 5'd1;
    assign any_new   = |new_alive;
    assign grow      = any_new && (len_p1 < 5'(MAX_LEN)) && ((N_BITS+1)'(len_p1) < size);
    assign fin_len   = any_new ? len_p1[3:0] : len;
    assign fin_dist  = any_new ? lowest_dist(new_alive) : lowest_dist(alive);
    assign fin_match = (fin_len >= 4'd2);
    // Byte 0 is only in cap from the second search cycle on.
    assign cap0      = (len == 4'd0) ? byte_n : cap[0];

    // History shift: newest retired byte (cap[n-1]) lands at hist[0].
    always_comb begin
        hist_nxt = hist;
        for (int j = 0; j < WINDOW; j++) begin
            if (j < int'(token_length))
                hist_nxt[j] = cap[CAP_IW'(int'(token_length) - 1 - j)];
            else
                hist_nxt[j] = hist[W_BITS'(j - int'(token_length))];
        end
    end

    assign cnt_sum = {1'b0, hist_count} + (W_BITS+2)'(token_length);
    assign cnt_nxt = (cnt_sum > (W_BITS+2)'(WINDOW)) ? (W_BITS+1)'(WINDOW) : cnt_sum[W_BITS:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_SEARCH;
            S_SEARCH:  if (!grow) state_nxt = S_EMIT;
            S_EMIT:    if (token_ready) state_nxt = S_CONSUME;
            S_CONSUME: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        token_valid    = (state == S_EMIT);
        get_byte_n     = (state == S_SEARCH) ? N_BITS'(len) : '0;
        remove_n_bytes = (state == S_CONSUME) ? N_BITS'(token_length) : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_count     <= '0;
            len            <= '0;
            alive          <= '0;
            token_is_match <= 1'b0;
            token_literal  <= '0;
            token_offset   <= '0;
            token_length   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    len   <= '0;
                    alive <= alive_init;
                end
                S_SEARCH: if (grow) begin
                    len   <= len_p1[3:0];
                    alive <= new_alive;
                end else begin
                    token_is_match <= fin_match;
                    token_literal  <= fin_match ? 8'h00 : cap0;
                    token_offset   <= fin_match ? W_BITS'(fin_dist - 1'b1) : '0;
                    token_length   <= fin_match ? fin_len : 4'd1;
                end
                S_CONSUME: hist_count <= cnt_nxt;
                default: ;
            endcase
        end
    end

    // Byte storage is masked by hist_count, so it carries no reset.
    always_ff @(posedge clock) begin
        if (state == S_SEARCH) cap[CAP_IW'(len)] <= byte_n;
        if (state == S_CONSUME) hist <= hist_nxt;
    end

`ifdef LZ_MATCH_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            literal_count <= '0;
            match_count   <= '0;
        end else if (token_valid && token_ready) begin
            if (token_is_match && (match_count != 16'hFFFF))
                match_count <= match_count + 16'd1;
            if (!token_is_match && (literal_count != 16'hFFFF))
                literal_count <= literal_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_lz_match_finder.sv
// Directed bench for lz_match_finder: look-ahead modelled as a byte stream consumed via remove_n_bytes.
module tb_lz_match_finder;
    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] size, byte_n;
    logic       flush;
    logic [6:0] get_byte_n, remove_n_bytes;
    logic       token_valid, token_ready, token_is_match;
    logic [7:0] token_literal;
    logic [3:0] token_offset, token_length;

    logic [7:0] stream [0:63];
    int         stream_len = 0;
    int         consumed;
    int         rd_idx;
    int         n_cmp = 0, n_err = 0;

    always #5 clock = ~clock;

    lz_match_finder dut (
        .clock(clock), .reset(reset), .size(size), .byte_n(byte_n), .flush(flush),
        .get_byte_n(get_byte_n), .remove_n_bytes(remove_n_bytes), .token_valid(token_valid),
        .token_ready(token_ready), .token_is_match(token_is_match), .token_literal(token_literal),
        .token_offset(token_offset), .token_length(token_length)
    );

    assign size   = 8'(stream_len - consumed);
    assign rd_idx = consumed + int'(get_byte_n);
    assign byte_n = (rd_idx < 64) ? stream[rd_idx[5:0]] : 8'h00;

    always @(posedge clock or negedge reset)
        if (!reset) consumed <= 0;
        else        consumed <= consumed + int'(remove_n_bytes);

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input string s);
        for (int i = 0; i < s.len(); i++) stream[i] = s[i];
        stream_len = s.len();
    endtask

    task automatic do_reset(input string s);
        reset = 1'b0;
        load(s);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_tok();
        int t = 0;
        while (!token_valid && t < 300) begin
            @(negedge clock);
            t++;
        end
    endtask

    task automatic check_fields(input string tag, input bit m, input int lit, input int off, input int len);
        chk({tag, ".valid"}, int'(token_valid), 1);
        chk({tag, ".match"}, int'(token_is_match), int'(m));
        chk({tag, ".lit"}, int'(token_literal), lit);
        chk({tag, ".off"}, int'(token_offset), off);
        chk({tag, ".len"}, int'(token_length), len);
        if (m) chk({tag, ".novl"}, int'(int'(token_length) <= int'(token_offset) + 1), 1);
    endtask

    task automatic expect_tok(input string tag, input bit m, input int lit, input int off, input int len);
        wait_tok();
        check_fields(tag, m, lit, off, len);
        @(negedge clock);
        chk({tag, ".rm"}, int'(remove_n_bytes), m ? len : 1);
        @(negedge clock);
        chk({tag, ".rm0"}, int'(remove_n_bytes), 0);
    endtask

    initial begin
        int t;
        reset = 1'b0;
        token_ready = 1'b1;
        flush = 1'b1;
        load("ABCDEFGHIJKLMNOP");
        #12;
        chk("rst.valid", int'(token_valid), 0);
        chk("rst.rm", int'(remove_n_bytes), 0);
        chk("rst.gb", int'(get_byte_n), 0);
        chk("rst.fields", int'({token_is_match, token_literal, token_offset, token_length}), 0);
        @(negedge clock);
        reset = 1'b1;

        // 16 distinct bytes: all literals.
        for (int i = 0; i < 16; i++)
            expect_tok($sformatf("lit%0d", i), 1'b0, 65 + i, 0, 1);

        // Run of identical bytes: overlap-free matches double each time.
        do_reset("AAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA");
        expect_tok("aa0", 1'b0, 65, 0, 1);
        expect_tok("aa1", 1'b0, 65, 0, 1);
        expect_tok("aa2", 1'b1, 0, 1, 2);
        expect_tok("aa3", 1'b1, 0, 3, 4);
        expect_tok("aa4", 1'b1, 0, 7, 8);

        // Match against ABCD history, held in EMIT for 10 cycles.
        do_reset("ABCDABCDxxxxxxxxxx");
        for (int i = 0; i < 4; i++)
            expect_tok($sformatf("abcd%0d", i), 1'b0, 65 + i, 0, 1);
        token_ready = 1'b0;
        wait_tok();
        for (int k = 0; k < 10; k++) begin
            check_fields($sformatf("hold%0d", k), 1'b1, 0, 3, 4);
            chk($sformatf("hold%0d.rm", k), int'(remove_n_bytes), 0);
            @(negedge clock);
        end
        token_ready = 1'b1;
        @(negedge clock);
        chk("hold.rm", int'(remove_n_bytes), 4);
        @(negedge clock);
        chk("hold.rm0", int'(remove_n_bytes), 0);

        // Flush with a short tail: search stops at the buffer size.
        do_reset("ABCABC");
        for (int i = 0; i < 3; i++)
            expect_tok($sformatf("abc%0d", i), 1'b0, 65 + i, 0, 1);
        expect_tok("tail", 1'b1, 0, 2, 3);

        // Reset in the middle of a search.
        do_reset("ABCDABCDxxxxxxxxxx");
        for (int i = 0; i < 4; i++)
            expect_tok($sformatf("pre%0d", i), 1'b0, 65 + i, 0, 1);
        t = 0;
        while (get_byte_n != 7'd2 && t < 100) begin
            @(negedge clock);
            t++;
        end
        chk("midsearch.gb", int'(get_byte_n), 2);
        #1 reset = 1'b0;
        #1;
        chk("arst.gb", int'(get_byte_n), 0);
        chk("arst.valid", int'(token_valid), 0);
        chk("arst.rm", int'(remove_n_bytes), 0);
        chk("arst.fields", int'({token_is_match, token_literal, token_offset, token_length}), 0);
        load("Q");
        @(negedge clock);
        reset = 1'b1;
        expect_tok("post", 1'b0, 81, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
